// File: rtl/dmem_arbiter_pkg.sv
// mem_pkg: shared types and constants for the data-RAM arbiter.
//   owner_state_t : arbiter owner state (IDLE, OWN_C, OWN_D)
//   PORT_C/PORT_D : port identifiers stored in the last-owner register
//   RAM_DATA/RAM_ADD : default data and word-address widths
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2
    } owner_state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int RAM_DATA = 32;
    localparam int RAM_ADD  = 10;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-RAM arbiter.
//   req/we/addr/wdata : request from the master (held until gnt)
//   gnt               : access accepted this cycle
//   rvalid/rdata      : read response, one cycle after a granted read
// Modports: master (requester side), slave (arbiter side).
interface dmem_arbiter_if #(
    parameter int RAM_DATA = mem_pkg::RAM_DATA,
    parameter int RAM_ADD  = mem_pkg::RAM_ADD
);
    logic                req;
    logic                we;
    logic [RAM_ADD-1:0]  addr;
    logic [RAM_DATA-1:0] wdata;
    logic                gnt;
    logic                rvalid;
    logic [RAM_DATA-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_rr_grant.sv
// rr_grant: combinational next-owner logic for the two-port arbiter.
//   i_state/i_bcnt/i_last : current owner, burst count, last owner
//   i_c_req/i_d_req       : port requests
//   o_gnt_c/o_gnt_d       : one-hot (or zero) grant for this cycle
//   o_state_nxt           : owner state for the next cycle
module rr_grant
    import mem_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int BCNT_W    = 3
) (
    input  owner_state_t      i_state,
    input  logic [BCNT_W-1:0] i_bcnt,
    input  logic              i_last,
    input  logic              i_c_req,
    input  logic              i_d_req,
    output logic              o_gnt_c,
    output logic              o_gnt_d,
    output owner_state_t      o_state_nxt
);

    localparam logic [BCNT_W-1:0] MAX_B = BCNT_W'(MAX_BURST);

    logic w_burst_ok;
    assign w_burst_ok = (i_bcnt < MAX_B);

    // Pick the winner: round-robin on ties, owner keeps the bus until its burst is spent.
    always_comb begin
        o_gnt_c     = 1'b0;
        o_gnt_d     = 1'b0;
        o_state_nxt = IDLE;
        case (i_state)
            IDLE: begin
                if (i_c_req && i_d_req) begin
                    if (i_last == PORT_D) begin
                        o_gnt_c = 1'b1;
                    end else begin
                        o_gnt_d = 1'b1;
                    end
                end else if (i_c_req) begin
                    o_gnt_c = 1'b1;
                end else if (i_d_req) begin
                    o_gnt_d = 1'b1;
                end else begin
                    o_gnt_c = 1'b0;
                end
            end
            OWN_C: begin
                if (i_c_req) begin
                    if (w_burst_ok || !i_d_req) begin
                        o_gnt_c = 1'b1;
                    end else begin
                        o_gnt_d = 1'b1;
                    end
                end else if (i_d_req) begin
                    o_gnt_d = 1'b1;
                end else begin
                    o_gnt_d = 1'b0;
                end
            end
            OWN_D: begin
                if (i_d_req) begin
                    if (w_burst_ok || !i_c_req) begin
                        o_gnt_d = 1'b1;
                    end else begin
                        o_gnt_c = 1'b1;
                    end
                end else if (i_c_req) begin
                    o_gnt_c = 1'b1;
                end else begin
                    o_gnt_c = 1'b0;
                end
            end
            default: begin
                o_gnt_c = 1'b0;
                o_gnt_d = 1'b0;
            end
        endcase

        if (o_gnt_c) begin
            o_state_nxt = OWN_C;
        end else if (o_gnt_d) begin
            o_state_nxt = OWN_D;
        end else begin
            o_state_nxt = IDLE;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of the single-port data RAM.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   c_port, d_port        : core and loader/debug DMA requester ports
//   o_ram_read/o_ram_write: RAM strobes from the granted port
//   o_ram_address/o_ram_datain : RAM address / write data (port C when idle)
//   i_ram_dataout         : RAM read data, valid the cycle after o_ram_read
module dmem_arbiter #(
    parameter int RAM_DATA  = mem_pkg::RAM_DATA,
    parameter int RAM_ADD   = mem_pkg::RAM_ADD,
    parameter int MAX_BURST = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    dmem_arbiter_if.slave       c_port,
    dmem_arbiter_if.slave       d_port,
    output logic                o_ram_read,
    output logic                o_ram_write,
    output logic [RAM_ADD-1:0]  o_ram_address,
    output logic [RAM_DATA-1:0] o_ram_datain,
    input  logic [RAM_DATA-1:0] i_ram_dataout
);
    import mem_pkg::*;

    localparam int                BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [BCNT_W-1:0] MAX_B  = BCNT_W'(MAX_BURST);

    owner_state_t      r_state;
    logic [BCNT_W-1:0] r_bcnt;
    logic              r_last;
    logic              r_c_rvalid;
    logic              r_d_rvalid;

    owner_state_t      w_state_nxt;
    logic              w_gnt_c_raw;
    logic              w_gnt_d_raw;
    logic              w_gnt_c;
    logic              w_gnt_d;

    rr_grant #(
        .MAX_BURST (MAX_BURST),
        .BCNT_W    (BCNT_W)
    ) u_rr_grant (
        .i_state     (r_state),
        .i_bcnt      (r_bcnt),
        .i_last      (r_last),
        .i_c_req     (c_port.req),
        .i_d_req     (d_port.req),
        .o_gnt_c     (w_gnt_c_raw),
        .o_gnt_d     (w_gnt_d_raw),
        .o_state_nxt (w_state_nxt)
    );

    // Grants are combinational from REQ, so mask them while reset is held
    // to keep the RAM strobes quiet until release.
    assign w_gnt_c = w_gnt_c_raw & i_rst_n;
    assign w_gnt_d = w_gnt_d_raw & i_rst_n;

    assign c_port.gnt    = w_gnt_c;
    assign d_port.gnt    = w_gnt_d;
    assign c_port.rvalid = r_c_rvalid;
    assign d_port.rvalid = r_d_rvalid;
    assign c_port.rdata  = i_ram_dataout;
    assign d_port.rdata  = i_ram_dataout;

    assign o_ram_write = (w_gnt_c & c_port.we) | (w_gnt_d & d_port.we);
    assign o_ram_read  = (w_gnt_c & ~c_port.we) | (w_gnt_d & ~d_port.we);

    // Steer RAM address and write data from the winner; port C when nobody is granted.
    always_comb begin
        o_ram_address = c_port.addr;
        o_ram_datain  = c_port.wdata;
        if (w_gnt_d) begin
            o_ram_address = d_port.addr;
            o_ram_datain  = d_port.wdata;
        end else begin
            o_ram_address = c_port.addr;
            o_ram_datain  = c_port.wdata;
        end
    end

    // Owner FSM with burst counter, last-owner memory and per-port read-valid flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_bcnt     <= '0;
            r_last     <= PORT_D;
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_c_rvalid <= w_gnt_c & ~c_port.we;
            r_d_rvalid <= w_gnt_d & ~d_port.we;
            if (w_gnt_c) begin
                if (r_state == OWN_C) begin
                    r_bcnt <= (r_bcnt == MAX_B) ? r_bcnt : r_bcnt + BCNT_W'(1);
                end else begin
                    r_bcnt <= BCNT_W'(1);
                    r_last <= PORT_C;
                end
            end else if (w_gnt_d) begin
                if (r_state == OWN_D) begin
                    r_bcnt <= (r_bcnt == MAX_B) ? r_bcnt : r_bcnt + BCNT_W'(1);
                end else begin
                    r_bcnt <= BCNT_W'(1);
                    r_last <= PORT_D;
                end
            end else begin
                r_bcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// behavioural single-port RAM (one-cycle read latency).
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ram_read;
    logic        ram_write;
    logic [9:0]  ram_address;
    logic [31:0] ram_datain;
    logic [31:0] ram_dataout;
    logic [31:0] mem [0:1023];

    int total = 0;
    int bad   = 0;

    dmem_arbiter_if c_if ();
    dmem_arbiter_if d_if ();

    dmem_arbiter #(.RAM_DATA(32), .RAM_ADD(10), .MAX_BURST(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .c_port        (c_if.slave),
        .d_port        (d_if.slave),
        .o_ram_read    (ram_read),
        .o_ram_write   (ram_write),
        .o_ram_address (ram_address),
        .o_ram_datain  (ram_datain),
        .i_ram_dataout (ram_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write at the edge, read data registered for the next cycle.
    always @(posedge clk) begin
        if (ram_write) mem[ram_address] <= ram_datain;
        if (ram_read)  ram_dataout <= mem[ram_address];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        c_if.req = 1'b1; c_if.we = 1'b0; c_if.addr = 10'h010; c_if.wdata = 32'h0;
        d_if.req = 1'b0; d_if.we = 1'b0; d_if.addr = 10'h020; d_if.wdata = 32'h0;
        #12;
        total++; if (c_if.gnt !== 1'b0) begin bad++; $display("FAIL rst_c_gnt: got %0b want 0", c_if.gnt); end
        total++; if (ram_read !== 1'b0) begin bad++; $display("FAIL rst_ram_read: got %0b want 0", ram_read); end
        total++; if (c_if.rvalid !== 1'b0) begin bad++; $display("FAIL rst_c_rvalid: got %0b want 0", c_if.rvalid); end
        total++; if (d_if.rvalid !== 1'b0) begin bad++; $display("FAIL rst_d_rvalid: got %0b want 0", d_if.rvalid); end
        c_if.req = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        total++; if (c_if.gnt !== 1'b0 || d_if.gnt !== 1'b0) begin bad++; $display("FAIL rst_idle_gnt: got c=%0b d=%0b want 0 0", c_if.gnt, d_if.gnt); end
        tick();
    endtask

    task automatic test_tie();
        c_if.req = 1'b1; c_if.we = 1'b0; c_if.addr = 10'h010;
        d_if.req = 1'b1; d_if.we = 1'b0; d_if.addr = 10'h020;
        settle();
        total++; if (c_if.gnt !== 1'b1 || d_if.gnt !== 1'b0) begin bad++; $display("FAIL tie_first: got c=%0b d=%0b want 1 0", c_if.gnt, d_if.gnt); end
        tick();
        c_if.req = 1'b0;
        settle();
        total++; if (d_if.gnt !== 1'b1 || c_if.gnt !== 1'b0) begin bad++; $display("FAIL tie_second: got c=%0b d=%0b want 0 1", c_if.gnt, d_if.gnt); end
        total++; if (c_if.rvalid !== 1'b1) begin bad++; $display("FAIL tie_c_rvalid: got %0b want 1", c_if.rvalid); end
        total++; if (c_if.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL tie_c_rdata: got %h want deadbeef", c_if.rdata); end
        tick();
        d_if.req = 1'b0;
        settle();
        total++; if (d_if.rvalid !== 1'b1) begin bad++; $display("FAIL tie_d_rvalid: got %0b want 1", d_if.rvalid); end
        total++; if (c_if.gnt !== 1'b0 || d_if.gnt !== 1'b0) begin bad++; $display("FAIL tie_idle: got c=%0b d=%0b want 0 0", c_if.gnt, d_if.gnt); end
        tick();
    endtask

    task automatic test_burst();
        logic exp_c;
        c_if.req = 1'b1; c_if.we = 1'b0; c_if.addr = 10'h010;
        d_if.req = 1'b1; d_if.we = 1'b0; d_if.addr = 10'h020;
        for (int i = 0; i < 12; i++) begin
            exp_c = ((i / 4) % 2) == 0;
            settle();
            total++; if (c_if.gnt !== exp_c || d_if.gnt !== !exp_c) begin bad++; $display("FAIL burst_cycle%0d: got c=%0b d=%0b want c=%0b d=%0b", i, c_if.gnt, d_if.gnt, exp_c, !exp_c); end
            tick();
        end
        c_if.req = 1'b0; d_if.req = 1'b0;
        settle();
        total++; if (c_if.gnt !== 1'b0 || d_if.gnt !== 1'b0) begin bad++; $display("FAIL burst_end: got c=%0b d=%0b want 0 0", c_if.gnt, d_if.gnt); end
        tick();
    endtask

    task automatic test_single_read();
        c_if.req = 1'b1; c_if.we = 1'b0; c_if.addr = 10'h010;
        settle();
        total++; if (c_if.gnt !== 1'b1 || d_if.gnt !== 1'b0) begin bad++; $display("FAIL rd_gnt: got c=%0b d=%0b want 1 0", c_if.gnt, d_if.gnt); end
        total++; if (ram_read !== 1'b1 || ram_write !== 1'b0) begin bad++; $display("FAIL rd_strobes: got r=%0b w=%0b want 1 0", ram_read, ram_write); end
        total++; if (ram_address !== 10'h010) begin bad++; $display("FAIL rd_addr: got %h want 010", ram_address); end
        tick();
        c_if.req = 1'b0;
        settle();
        total++; if (c_if.rvalid !== 1'b1 || c_if.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_resp: got v=%0b d=%h want 1 deadbeef", c_if.rvalid, c_if.rdata); end
        total++; if (d_if.rvalid !== 1'b0) begin bad++; $display("FAIL rd_d_rvalid: got %0b want 0", d_if.rvalid); end
        total++; if (ram_read !== 1'b0) begin bad++; $display("FAIL rd_idle_read: got %0b want 0", ram_read); end
        tick();
        total++; if (c_if.rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_drop: got %0b want 0", c_if.rvalid); end
    endtask

    task automatic test_d_stream();
        d_if.req = 1'b1; d_if.we = 1'b1; d_if.addr = 10'h020; d_if.wdata = 32'hA5A5A5A5;
        for (int i = 0; i < 10; i++) begin
            settle();
            total++; if (d_if.gnt !== 1'b1 || c_if.gnt !== 1'b0) begin bad++; $display("FAIL dstream_cycle%0d: got c=%0b d=%0b want 0 1", i, c_if.gnt, d_if.gnt); end
            tick();
        end
        c_if.req = 1'b1; c_if.we = 1'b0; c_if.addr = 10'h010;
        settle();
        total++; if (c_if.gnt !== 1'b1 || d_if.gnt !== 1'b0) begin bad++; $display("FAIL dstream_c_in: got c=%0b d=%0b want 1 0", c_if.gnt, d_if.gnt); end
        tick();
        c_if.req = 1'b0;
        settle();
        total++; if (d_if.gnt !== 1'b1) begin bad++; $display("FAIL dstream_d_back: got %0b want 1", d_if.gnt); end
        total++; if (c_if.rvalid !== 1'b1 || c_if.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL dstream_c_resp: got v=%0b d=%h want 1 deadbeef", c_if.rvalid, c_if.rdata); end
        tick();
        d_if.req = 1'b0; d_if.we = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        d_if.req = 1'b1; d_if.we = 1'b1; d_if.addr = 10'h3FF; d_if.wdata = 32'h12345678;
        settle();
        total++; if (d_if.gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt: got %0b want 1", d_if.gnt); end
        total++; if (ram_write !== 1'b1 || ram_read !== 1'b0) begin bad++; $display("FAIL wr_strobes: got r=%0b w=%0b want 0 1", ram_read, ram_write); end
        total++; if (ram_address !== 10'h3FF || ram_datain !== 32'h12345678) begin bad++; $display("FAIL wr_bus: got a=%h d=%h want 3ff 12345678", ram_address, ram_datain); end
        tick();
        d_if.req = 1'b0; d_if.we = 1'b0;
        c_if.req = 1'b1; c_if.we = 1'b0; c_if.addr = 10'h3FF;
        settle();
        total++; if (c_if.gnt !== 1'b1 || ram_read !== 1'b1 || ram_write !== 1'b0) begin bad++; $display("FAIL wr_rd_issue: got g=%0b r=%0b w=%0b want 1 1 0", c_if.gnt, ram_read, ram_write); end
        total++; if (ram_address !== 10'h3FF) begin bad++; $display("FAIL wr_rd_addr: got %h want 3ff", ram_address); end
        tick();
        c_if.req = 1'b0;
        d_if.req = 1'b1; d_if.we = 1'b0; d_if.addr = 10'h3FF;
        settle();
        total++; if (c_if.rvalid !== 1'b1 || c_if.rdata !== 32'h12345678) begin bad++; $display("FAIL wr_rd_data: got v=%0b d=%h want 1 12345678", c_if.rvalid, c_if.rdata); end
        total++; if (d_if.gnt !== 1'b1) begin bad++; $display("FAIL wr_drd_gnt: got %0b want 1", d_if.gnt); end
        tick();
        d_if.req = 1'b0;
        settle();
        total++; if (d_if.rvalid !== 1'b1 || d_if.rdata !== 32'h12345678) begin bad++; $display("FAIL wr_drd_data: got v=%0b d=%h want 1 12345678", d_if.rvalid, d_if.rdata); end
        total++; if (c_if.rvalid !== 1'b0) begin bad++; $display("FAIL wr_drd_c_rvalid: got %0b want 0", c_if.rvalid); end
        tick();
    endtask

    task automatic test_reset_mid();
        c_if.req = 1'b1; c_if.we = 1'b0; c_if.addr = 10'h010;
        settle();
        total++; if (c_if.gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt: got %0b want 1", c_if.gnt); end
        tick();
        d_if.req = 1'b1; d_if.we = 1'b0; d_if.addr = 10'h020;
        total++; if (c_if.rvalid !== 1'b1) begin bad++; $display("FAIL rmid_pending: got %0b want 1", c_if.rvalid); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (c_if.rvalid !== 1'b0) begin bad++; $display("FAIL rmid_rvalid_clr: got %0b want 0", c_if.rvalid); end
        total++; if (c_if.gnt !== 1'b0 || d_if.gnt !== 1'b0) begin bad++; $display("FAIL rmid_gnt_off: got c=%0b d=%0b want 0 0", c_if.gnt, d_if.gnt); end
        total++; if (ram_read !== 1'b0 || ram_write !== 1'b0) begin bad++; $display("FAIL rmid_strobes: got r=%0b w=%0b want 0 0", ram_read, ram_write); end
        tick();
        total++; if (ram_read !== 1'b0 || c_if.rvalid !== 1'b0) begin bad++; $display("FAIL rmid_held: got r=%0b v=%0b want 0 0", ram_read, c_if.rvalid); end
        rst_n = 1'b1;
        settle();
        total++; if (c_if.gnt !== 1'b1 || d_if.gnt !== 1'b0) begin bad++; $display("FAIL rmid_tie: got c=%0b d=%0b want 1 0", c_if.gnt, d_if.gnt); end
        tick();
        c_if.req = 1'b0; d_if.req = 1'b0;
        tick();
    endtask

    initial begin
        mem[16] = 32'hDEADBEEF;
        test_reset();
        test_tie();
        test_burst();
        test_single_read();
        test_d_stream();
        test_write_read();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data RAM. It sits between the RAM instance and two masters: the CORE data port (port C) and a loader/debug DMA port (port D). It grants one access per cycle using round-robin arbitration with a bounded burst hold, drives the RAM control, address and data lines from the winner, and steers read-response valids back to the port that issued each read.

## Interface
- RAM_DATA, 32, data width
- RAM_ADD, 10, word address width
- MAX_BURST, 4, maximum consecutive grants to one owner while the other port is requesting (≥1)

- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- C_REQ  in  1  core access request
- C_WE  in  1  1 = write, 0 = read
- C_ADDR  in  RAM_ADD  core address
- C_WDATA  in  RAM_DATA  core write data
- C_GNT  out  1  access accepted this cycle
- C_RVALID  out  1  C_RDATA valid (read issued last cycle)
- C_RDATA  out  RAM_DATA  read data
- D_REQ, D_WE, D_ADDR, D_WDATA, D_GNT, D_RVALID, D_RDATA  same as the C_ ports, for port D
- RAM_READ  out  1  RAM read strobe
- RAM_WRITE  out  1  RAM write strobe
- RAM_ADDRESS  out  RAM_ADD  RAM address
- RAM_DATAIN  out  RAM_DATA  RAM write data
- RAM_DATAOUT  in  RAM_DATA  RAM read data, valid the cycle after RAM_READ

## Operation
- FSM states: IDLE, OWN_C, OWN_D. A burst counter BCNT (0..MAX_BURST) and a LAST register (last owner) are held with the state.
- IDLE:
  - Only one port requesting: grant that port.
  - Both ports requesting: grant the port that is not LAST.
  - No request: stay in IDLE.
- OWN_X, X requesting:
  - If BCNT < MAX_BURST, or the other port is idle: grant X again and increment BCNT, saturating at MAX_BURST.
  - If BCNT = MAX_BURST and the other port is requesting: grant the other port.
- OWN_X, X idle: grant the other port if it is requesting; otherwise go to IDLE.
- Switching owner: BCNT = 1 and LAST is set to the new owner.
- GNT is combinational from the state and both REQ inputs. At most one GNT is high per cycle. The granted access completes in that same cycle.
- RAM outputs:
  - RAM_ADDRESS and RAM_DATAIN are muxed from the granted port.
  - RAM_WRITE = GNT & WE; RAM_READ = GNT & ~WE.
  - With no grant, RAM_READ and RAM_WRITE are 0, and ADDRESS/DATAIN hold port C's values (don't-care).
- Read return:
  - C_RDATA and D_RDATA are both wired to RAM_DATAOUT.
  - X_RVALID is a flop set to (X_GNT & ~X_WE) in the previous cycle.
- A requester must hold REQ, WE, ADDR and WDATA stable until it sees GNT.

## Timing
- Reset values: state IDLE, BCNT 0, LAST = D (port C wins the first tie), C_RVALID = D_RVALID = 0. All GNT and RAM strobes are 0 while RESET_N is low.
- Grant latency is 0 cycles: REQ and GNT can both be high in the same cycle.
- Read latency: data and RVALID appear 1 cycle after the grant. Back-to-back reads give RVALID every cycle.
- Read and write may alternate on consecutive cycles. A write followed by a read to the same address returns the new data.
- Reset mid-operation clears pending RVALIDs and the burst state immediately. No RAM strobe is issued until after RESET_N is released.
- Worst-case wait for a requester is MAX_BURST cycles.

## Structure
- The shared package `mem_pkg` holds:
  - the owner state enum: IDLE, OWN_C, OWN_D
  - the port-ID constants PORT_C and PORT_D
  - the default widths RAM_DATA and RAM_ADD
- One sub-module, `rr_grant`: the combinational next-owner/grant logic (state, BCNT, LAST, the REQs in; the GNTs and next state out). The flops and the RAM mux live in `dmem_arbiter`.
- At the top level, `dmem_arbiter` is inserted between CORE_INST and RAM_INST.

## Test plan
- After reset, C_REQ alone, read at 0x010 holding 0xDEADBEEF → C_GNT in the same cycle, RAM_READ=1, C_RVALID=1 with C_RDATA=0xDEADBEEF the next cycle, D_RVALID=0.
- C_REQ and D_REQ rise together from IDLE → C granted first; after C drops, D is granted the next cycle.
- C and D both held requesting, MAX_BURST=4 → grant pattern C,C,C,C,D,D,D,D,C…; no cycle with both GNTs high.
- D alone requesting for 10 cycles → D_GNT every cycle (BCNT saturates, no bubble); C_REQ rises → C granted within ≤4 cycles.
- D writes 0x12345678 to 0x3FF, then C reads 0x3FF the next cycle → RAM_WRITE then RAM_READ; C_RDATA=0x12345678 with C_RVALID.
- RESET_N pulsed low while a C read is outstanding → C_RVALID=0 immediately, state IDLE, and after release the first tie is granted to C.
